mem_bus_mux: RTL and testbench

- Two-requester round-robin arbiter that merges the core's instruction-fetch port (s0) and load/store port (s1) onto the single valid/ready memory bus.
- Its output drives the slave port of the address-decoding bus arbiter.
- Holds the grant for the full transaction.
- Provides a watchdog that terminates transfers the downstream never acknowledges.

---
 rtl/mem_bus_mux.sv | 121 ++++++++++++
 tb/tb_mem_bus_mux.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_mux.sv
// Two-requester round-robin front end for the single valid/ready memory bus.
// The grant is held for a whole transfer, and a watchdog forces completion of stalled transfers.
module mem_bus_mux #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned WORD_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter logic [WORD_WIDTH-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  s0_valid_i,
   output logic                  s0_ready_o,
   input  logic [ADDR_WIDTH-1:0] s0_addr_i,
   input  logic [WORD_WIDTH-1:0] s0_wdata_i,
   input  logic [3:0]            s0_we_i,
   output logic [WORD_WIDTH-1:0] s0_rdata_o,
   input  logic                  s1_valid_i,
   output logic                  s1_ready_o,
   input  logic [ADDR_WIDTH-1:0] s1_addr_i,
   input  logic [WORD_WIDTH-1:0] s1_wdata_i,
   input  logic [3:0]            s1_we_i,
   output logic [WORD_WIDTH-1:0] s1_rdata_o,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic [ADDR_WIDTH-1:0] m_addr_o,
   output logic [WORD_WIDTH-1:0] m_wdata_o,
   output logic [3:0]            m_we_o,
   input  logic [WORD_WIDTH-1:0] m_rdata_i,
   output logic                  timeout_o
);

   localparam int unsigned WD_W = (TIMEOUT_CYCLES <= 1) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYCLES <= 1) ? '0 : WD_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic {IDLE, BUSY} state_e;

   state_e           state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_q, last_d;
   logic [WD_W-1:0]  wd_q, wd_d;

   logic                  own_valid;
   logic                  done;
   logic [WORD_WIDTH-1:0] rdata;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         wd_q    <= wd_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      wd_d       = wd_q;
      m_valid_o  = 1'b0;
      m_addr_o   = '0;
      m_wdata_o  = '0;
      m_we_o     = '0;
      s0_ready_o = 1'b0;
      s1_ready_o = 1'b0;
      s0_rdata_o = '0;
      s1_rdata_o = '0;
      timeout_o  = 1'b0;
      done       = 1'b0;
      rdata      = m_rdata_i;
      own_valid  = owner_q ? s1_valid_i : s0_valid_i;

      case (state_q)
         IDLE: begin
            if (s0_valid_i || s1_valid_i) begin
               state_d = BUSY;
               owner_d = (s0_valid_i && s1_valid_i) ? ~last_q : s1_valid_i;
               wd_d    = '0;
            end
         end
         BUSY: begin
            m_valid_o = own_valid;
            m_addr_o  = owner_q ? s1_addr_i  : s0_addr_i;
            m_wdata_o = owner_q ? s1_wdata_i : s0_wdata_i;
            m_we_o    = owner_q ? s1_we_i    : s0_we_i;
            // Owner withdrawing its request abandons the transfer without touching fairness.
            if (!own_valid) begin
               state_d = IDLE;
               wd_d    = '0;
            end else if (m_ready_i) begin
               done = 1'b1;
            end else if ((TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST)) begin
               done      = 1'b1;
               timeout_o = 1'b1;
               rdata     = TIMEOUT_RDATA;
            end else if (wd_q != '1) begin
               wd_d = wd_q + WD_W'(1);
            end
            if (done) begin
               state_d = IDLE;
               wd_d    = '0;
               last_d  = owner_q;
               if (owner_q) begin
                  s1_ready_o = 1'b1;
                  s1_rdata_o = rdata;
               end else begin
                  s0_ready_o = 1'b1;
                  s0_rdata_o = rdata;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_bus_mux.sv
// Bench for mem_bus_mux: a transaction-level reference model predicts bus activity and completions,
// and a separate monitor compares the DUT against those predictions each cycle.
module tb_mem_bus_mux;

   localparam int TO = 4;
   localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;

   logic        clk, rst_n;
   logic        s0_valid, s0_ready, s1_valid, s1_ready;
   logic [31:0] s0_addr, s0_wdata, s0_rdata, s1_addr, s1_wdata, s1_rdata;
   logic [3:0]  s0_we, s1_we, m_we;
   logic        m_valid, m_ready, timeout;
   logic [31:0] m_addr, m_wdata, m_rdata;

   mem_bus_mux #(.ADDR_WIDTH(32), .WORD_WIDTH(32), .TIMEOUT_CYCLES(TO), .TIMEOUT_RDATA(TO_DATA)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .s0_valid_i(s0_valid), .s0_ready_o(s0_ready), .s0_addr_i(s0_addr), .s0_wdata_i(s0_wdata),
      .s0_we_i(s0_we), .s0_rdata_o(s0_rdata),
      .s1_valid_i(s1_valid), .s1_ready_o(s1_ready), .s1_addr_i(s1_addr), .s1_wdata_i(s1_wdata),
      .s1_we_i(s1_we), .s1_rdata_o(s1_rdata),
      .m_valid_o(m_valid), .m_ready_i(m_ready), .m_addr_o(m_addr), .m_wdata_o(m_wdata),
      .m_we_o(m_we), .m_rdata_i(m_rdata), .timeout_o(timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int errs = 0;
   int checks = 0;

   task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         errs++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {int cyc; int port; logic [31:0] rdata; bit to;} cmp_t;
   typedef struct {int cyc; bit rst; bit v; logic [31:0] a; logic [31:0] w; logic [3:0] we;} bus_t;
   cmp_t sbq[$];
   bus_t busq[$];

   // Reference model: a port's transfer is granted when the bus is free (ties go to whoever
   // did not finish last), and ends on an ack, on the requester giving up, or after TO
   // consecutive unacknowledged busy cycles.
   int cyc_n = 0;
   bit mbusy = 0;
   int mown = 0, mprev = 1, mwait = 0;
   bit done0, done1;

   always @(negedge clk) begin
      bus_t b;
      bit ov;
      cyc_n++;
      done0 = 0;
      done1 = 0;
      b = '{cyc: cyc_n, rst: 0, v: 0, a: 0, w: 0, we: 0};
      if (!rst_n) begin
         b.rst = 1;
         mbusy = 0; mprev = 1; mwait = 0;
      end else if (!mbusy) begin
         if (s0_valid || s1_valid) begin
            mown  = (s0_valid && s1_valid) ? 1 - mprev : (s0_valid ? 0 : 1);
            mbusy = 1;
            mwait = 0;
         end
      end else begin
         ov   = (mown == 1) ? s1_valid : s0_valid;
         b.v  = ov;
         b.a  = (mown == 1) ? s1_addr  : s0_addr;
         b.w  = (mown == 1) ? s1_wdata : s0_wdata;
         b.we = (mown == 1) ? s1_we    : s0_we;
         if (!ov) begin
            mbusy = 0;
         end else if (m_ready || (mwait + 1 >= TO)) begin
            sbq.push_back('{cyc: cyc_n, port: mown, rdata: m_ready ? m_rdata : TO_DATA, to: !m_ready});
            if (mown == 1) done1 = 1; else done0 = 1;
            mprev = mown;
            mbusy = 0;
         end else begin
            mwait++;
         end
      end
      busq.push_back(b);
   end

   // Monitor: consumes one bus expectation per cycle, and a completion whenever one is due.
   always begin
      bus_t b;
      cmp_t e;
      @(negedge clk);
      #2;
      if (busq.size() != 0) begin
         b = busq.pop_front();
         if (b.rst) begin
            check(m_valid == 0 && m_we == 0, "reset_m_valid_we", {27'd0, m_valid, m_we}, 32'd0);
            check(m_addr == 0 && m_wdata == 0, "reset_m_addr_wdata", m_addr | m_wdata, 32'd0);
         end else begin
            check(m_valid == b.v, "m_valid", {31'd0, m_valid}, {31'd0, b.v});
            if (b.v) begin
               check(m_addr == b.a, "m_addr", m_addr, b.a);
               check(m_wdata == b.w, "m_wdata", m_wdata, b.w);
               check(m_we == b.we, "m_we", {28'd0, m_we}, {28'd0, b.we});
            end
         end
      end
      if (sbq.size() != 0 && sbq[0].cyc == cyc_n) begin
         e = sbq.pop_front();
         check({s1_ready, s0_ready} == ((e.port == 1) ? 2'b10 : 2'b01), "ready_port",
               {30'd0, s1_ready, s0_ready}, (e.port == 1) ? 32'd2 : 32'd1);
         check(((e.port == 1) ? s1_rdata : s0_rdata) == e.rdata, "rdata",
               (e.port == 1) ? s1_rdata : s0_rdata, e.rdata);
         check(timeout == e.to, "timeout", {31'd0, timeout}, {31'd0, e.to});
      end else begin
         check(!s0_ready && !s1_ready && !timeout, "spurious_ready",
               {29'd0, timeout, s1_ready, s0_ready}, 32'd0);
      end
      if (!s0_ready) check(s0_rdata == 0, "s0_rdata_idle", s0_rdata, 32'd0);
      if (!s1_ready) check(s1_rdata == 0, "s1_rdata_idle", s1_rdata, 32'd0);
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   bit act0, act1;

   initial begin
      rst_n = 0;
      s0_valid = 0; s0_addr = 0; s0_wdata = 0; s0_we = 0;
      s1_valid = 0; s1_addr = 0; s1_wdata = 0; s1_we = 0;
      m_ready = 0; m_rdata = 0;
      cyc(3);
      rst_n = 1;
      cyc();

      // Simultaneous requests from reset, zero-wait downstream: s0, s1, s0, s1.
      s0_valid = 1; s0_addr = 32'h10;  s0_wdata = 32'h1; s0_we = 4'h0;
      s1_valid = 1; s1_addr = 32'h800; s1_wdata = 32'h2; s1_we = 4'h0;
      m_ready = 1; m_rdata = 32'hCAFE_0001;
      cyc(8);
      s0_valid = 0; s1_valid = 0;
      cyc(2);

      // Single read on s0.
      s0_valid = 1; s0_addr = 32'h100; m_ready = 1; m_rdata = 32'h1234_5678;
      cyc(2);
      s0_valid = 0; m_ready = 0;
      cyc(2);

      // Write on s1 with 3 wait states; ack lands in the watchdog expiry cycle.
      s1_valid = 1; s1_addr = 32'h1004; s1_wdata = 32'hA5A5_0F0F; s1_we = 4'b0011;
      m_ready = 0; m_rdata = 32'h5555_AAAA;
      cyc(4);
      m_ready = 1;
      cyc();
      s1_valid = 0; m_ready = 0;
      cyc(2);

      // Watchdog expiry on s0.
      s0_valid = 1; s0_addr = 32'h200; m_ready = 0;
      cyc(5);
      s0_valid = 0;
      cyc(2);

      // Abort by s1 in its 2nd busy cycle, then a tie.
      s1_valid = 1; s1_addr = 32'h300;
      cyc(2);
      s1_valid = 0;
      cyc();
      s0_valid = 1; s1_valid = 1; m_ready = 1; m_rdata = 32'h0BAD_F00D;
      cyc(4);
      s0_valid = 0; s1_valid = 0; m_ready = 0;
      cyc(2);

      // Asynchronous reset mid-transfer, then a tie after release.
      s0_valid = 1; s0_addr = 32'h400;
      cyc(2);
      #2 rst_n = 0;
      #1;
      check(m_valid == 0 && !s0_ready && !s1_ready && !timeout, "async_reset_ctrl",
            {28'd0, m_valid, timeout, s1_ready, s0_ready}, 32'd0);
      check(s0_rdata == 0 && s1_rdata == 0, "async_reset_rdata", s0_rdata | s1_rdata, 32'd0);
      cyc();
      rst_n = 1; s1_valid = 1; m_ready = 1; m_rdata = 32'h7777_0000;
      cyc(4);
      s0_valid = 0; s1_valid = 0; m_ready = 0;
      cyc(2);

      // Random traffic.
      act0 = 0; act1 = 0;
      for (int i = 0; i < 3000; i++) begin
         if (done0) act0 = 0;
         if (done1) act1 = 0;
         if (!act0 && $urandom_range(2) == 0) begin
            act0 = 1; s0_addr = $urandom; s0_wdata = $urandom; s0_we = 4'($urandom);
         end else if (act0 && $urandom_range(39) == 0) begin
            act0 = 0;
         end
         if (!act1 && $urandom_range(2) == 0) begin
            act1 = 1; s1_addr = $urandom; s1_wdata = $urandom; s1_we = 4'($urandom);
         end else if (act1 && $urandom_range(39) == 0) begin
            act1 = 0;
         end
         s0_valid = act0;
         s1_valid = act1;
         m_ready  = ($urandom_range(9) < 4);
         m_rdata  = $urandom;
         rst_n    = ($urandom_range(499) != 0);
         cyc();
      end
      rst_n = 1; s0_valid = 0; s1_valid = 0; m_ready = 0;
      cyc(3);
      check(sbq.size() == 0, "scoreboard_drained", sbq.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
